// File: rtl/ssm_tile_seq_fp16.sv
// Tile-loop sequencer for one SSM step (dBx, update, y=h.C, optional D.x) over NT tiles of HT heads each.
// A stage costs done-latency+1 cycles; y_flat is held in OUT until out_ready, and no job is accepted meanwhile.
module ssm_tile_seq_fp16 #(
   parameter int H      = 24,
   parameter int HT     = 4,
   parameter int P      = 64,
   parameter int DW     = 16,
   parameter int TO_MAX = 1024,
   localparam int NT    = H / HT,
   localparam int TW    = (NT > 1) ? $clog2(NT) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode_res,
   input  logic                 abort,
   output logic                 start_dbx,
   output logic                 start_upd,
   output logic                 start_ycalc,
   output logic                 start_res,
   input  logic                 done_dbx,
   input  logic                 done_upd,
   input  logic                 done_ycalc,
   input  logic                 done_res,
   output logic [TW-1:0]        tile_idx,
   input  logic [HT*P*DW-1:0]   y_tile_in,
   output logic [H*P*DW-1:0]    y_flat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 err_timeout
);
   localparam int SW = HT * P * DW;
   localparam int CW = (TO_MAX > 2) ? $clog2(TO_MAX) : 1;

   typedef enum logic [2:0] {IDLE, DBX, UPD, YC, RES, OUT, ERR} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          mode_r;
   logic          stage_done;
   logic          acc;
   logic          timeout;
   logic          last_tile;
   logic          tile_end;
   logic          kill;

   always_comb begin
      stage_done = 1'b0;
      case (state)
         DBX:     stage_done = done_dbx;
         UPD:     stage_done = done_upd;
         YC:      stage_done = done_ycalc;
         RES:     stage_done = done_res;
         default: stage_done = 1'b0;
      endcase
   end

   // cnt is zero only in the pulse cycle, so a done there is ignored
   assign acc       = (cnt != '0) && stage_done;
   assign timeout   = (cnt == CW'(TO_MAX - 1));
   assign last_tile = (tile_idx == TW'(NT - 1));
   assign tile_end  = acc && (((state == YC) && !mode_r) || (state == RES));
   assign kill      = abort && (state != IDLE);
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tile_idx    <= '0;
         cnt         <= '0;
         mode_r      <= 1'b0;
         out_valid   <= 1'b0;
         err_timeout <= 1'b0;
         start_dbx   <= 1'b0;
         start_upd   <= 1'b0;
         start_ycalc <= 1'b0;
         start_res   <= 1'b0;
      end else begin
         start_dbx   <= 1'b0;
         start_upd   <= 1'b0;
         start_ycalc <= 1'b0;
         start_res   <= 1'b0;
         if (kill) begin
            state       <= IDLE;
            tile_idx    <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (in_valid) begin
                     mode_r    <= mode_res;
                     tile_idx  <= '0;
                     cnt       <= '0;
                     state     <= DBX;
                     start_dbx <= 1'b1;
                  end
               end
               DBX, UPD, YC, RES: begin
                  if (acc) begin
                     cnt <= '0;
                     if (tile_end) begin
                        if (last_tile) begin
                           state     <= OUT;
                           out_valid <= 1'b1;
                        end else begin
                           tile_idx  <= tile_idx + TW'(1);
                           state     <= DBX;
                           start_dbx <= 1'b1;
                        end
                     end else begin
                        case (state)
                           DBX: begin
                              state     <= UPD;
                              start_upd <= 1'b1;
                           end
                           UPD: begin
                              state       <= YC;
                              start_ycalc <= 1'b1;
                           end
                           YC: begin
                              state     <= RES;
                              start_res <= 1'b1;
                           end
                           default: state <= state;
                        endcase
                     end
                  end else if (timeout) begin
                     state       <= ERR;
                     err_timeout <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               OUT: begin
                  if (out_ready) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     tile_idx  <= '0;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

   // abort wins over a same-cycle tile end; earlier tiles stay as written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_flat <= '0;
      end else if (tile_end && !abort) begin
         for (int t = 0; t < NT; t++) begin
            if (tile_idx == TW'(t)) y_flat[t*SW +: SW] <= y_tile_in;
         end
      end
   end

endmodule

// File: tb/tb_ssm_tile_seq_fp16.sv
// Directed bench for ssm_tile_seq_fp16 with H=8, HT=4, TO_MAX=10 and done stubs answering k=3 cycles after each start.
module tb_ssm_tile_seq_fp16;
   localparam int H      = 8;
   localparam int HT     = 4;
   localparam int P      = 4;
   localparam int DW     = 16;
   localparam int TO_MAX = 10;
   localparam int TW     = 1;
   localparam int SW     = HT * P * DW;
   localparam int YW     = H * P * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mode_res = 1'b0;
   logic          abort = 1'b0;
   logic          start_dbx, start_upd, start_ycalc, start_res;
   logic          done_dbx = 1'b0, done_upd = 1'b0, done_ycalc = 1'b0, done_res = 1'b0;
   logic [TW-1:0] tile_idx;
   logic [SW-1:0] y_tile_in;
   logic [SW-1:0] pat0 = '0, pat1 = '0;
   logic [YW-1:0] y_flat;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          err_timeout;

   logic          en_upd = 1'b1;
   logic          spur_res = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;

   ssm_tile_seq_fp16 #(.H(H), .HT(HT), .P(P), .DW(DW), .TO_MAX(TO_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode_res(mode_res),
      .abort(abort), .start_dbx(start_dbx), .start_upd(start_upd), .start_ycalc(start_ycalc),
      .start_res(start_res), .done_dbx(done_dbx), .done_upd(done_upd), .done_ycalc(done_ycalc),
      .done_res(done_res), .tile_idx(tile_idx), .y_tile_in(y_tile_in), .y_flat(y_flat),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign y_tile_in = tile_idx[0] ? pat1 : pat0;

   // done stubs: each done pulses exactly 3 cycles after its start pulse
   initial begin
      int c_d, c_u, c_y, c_r;
      c_d = 0; c_u = 0; c_y = 0; c_r = 0;
      forever begin
         @(posedge clk);
         #2;
         done_dbx   = (c_d == 1);
         done_upd   = en_upd && (c_u == 1);
         done_ycalc = (c_y == 1);
         done_res   = (c_r == 1) || spur_res;
         if (c_d > 0) c_d--;
         if (c_u > 0) c_u--;
         if (c_y > 0) c_y--;
         if (c_r > 0) c_r--;
         if (start_dbx)   c_d = 3;
         if (start_upd)   c_u = 3;
         if (start_ycalc) c_y = 3;
         if (start_res)   c_r = 3;
      end
   end

   task automatic chk(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] mk(input logic [31:0] w);
      return {8{w}};
   endfunction

   // seq collects one nibble per start pulse: {tile_idx[0], stage 1..4}
   task automatic run_job(input logic m, input logic [SW-1:0] p0, input logic [SW-1:0] p1,
                          output int lat, output logic [31:0] seq);
      int a;
      lat = -1;
      seq = '0;
      pat0 = p0;
      pat1 = p1;
      mode_res = m;
      in_valid = 1'b1;
      chk("accept_in_ready", in_ready, 1);
      a = cyc;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (start_dbx)   seq = {seq[27:0], tile_idx[0], 3'd1};
         if (start_upd)   seq = {seq[27:0], tile_idx[0], 3'd2};
         if (start_ycalc) seq = {seq[27:0], tile_idx[0], 3'd3};
         if (start_res)   seq = {seq[27:0], tile_idx[0], 3'd4};
         if (out_valid) begin
            lat = cyc - a;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int            lat, s, e, n;
      logic [31:0]   seq;

      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_starts", {start_dbx, start_upd, start_ycalc, start_res}, 0);
      chk("rst_tile_idx", tile_idx, 0);
      chk("rst_y_flat", y_flat, 0);
      #12 rst_n = 1'b1;
      tick();
      tick();

      // residual mode, free-flowing output
      run_job(1'b1, mk(32'h1111_0000), mk(32'h1111_0001), lat, seq);
      chk("A_latency", lat, 33);
      chk("A_order", seq, 32'h1234_9ABC);
      chk("A_y", y_flat, {mk(32'h1111_0001), mk(32'h1111_0000)});
      tick();
      chk("A_in_ready_next", in_ready, 1);
      chk("A_out_valid_drop", out_valid, 0);

      // no residual, done_res held high throughout
      spur_res = 1'b1;
      run_job(1'b0, mk(32'h2222_0000), mk(32'h2222_0001), lat, seq);
      spur_res = 1'b0;
      chk("B_latency", lat, 25);
      chk("B_order", seq, 32'h0012_39AB);
      chk("B_y", y_flat, {mk(32'h2222_0001), mk(32'h2222_0000)});
      tick();
      chk("B_in_ready_next", in_ready, 1);

      // abort in the cycle done_ycalc arrives in tile 1
      pat0 = mk(32'h3333_0000);
      pat1 = mk(32'h3333_0001);
      mode_res = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!(start_ycalc && tile_idx == 1'b1) && n < 200) begin
         tick();
         n++;
      end
      chk("C_reach_t1_ycalc", (n < 200), 1);
      tick();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("C_busy", busy, 0);
      chk("C_in_ready", in_ready, 1);
      chk("C_tile_idx", tile_idx, 0);
      chk("C_out_valid", out_valid, 0);
      chk("C_y_partial", y_flat, {mk(32'h2222_0001), mk(32'h3333_0000)});
      n = 0;
      repeat (6) begin
         tick();
         if (out_valid || busy) n++;
      end
      chk("C_quiet", n, 0);

      run_job(1'b1, mk(32'h4444_0000), mk(32'h4444_0001), lat, seq);
      chk("D_latency", lat, 33);
      chk("D_order", seq, 32'h1234_9ABC);
      chk("D_y", y_flat, {mk(32'h4444_0001), mk(32'h4444_0000)});
      tick();

      // output backpressure for 5 cycles
      out_ready = 1'b0;
      run_job(1'b1, mk(32'h5555_0000), mk(32'h5555_0001), lat, seq);
      chk("E_latency", lat, 33);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         chk("E_hold_valid", out_valid, 1);
         chk("E_hold_y", y_flat, {mk(32'h5555_0001), mk(32'h5555_0000)});
         chk("E_hold_in_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("E_valid_at_accept", out_valid, 1);
      tick();
      chk("E_out_valid_drop", out_valid, 0);
      chk("E_in_ready", in_ready, 1);
      tick();
      chk("E_stay_idle", busy, 0);

      // watchdog on a stalled update stage
      en_upd = 1'b0;
      mode_res = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!start_upd && n < 50) begin
         tick();
         n++;
      end
      s = cyc;
      n = 0;
      while (!err_timeout && n < 50) begin
         tick();
         n++;
      end
      e = cyc;
      chk("W_timeout_cycles", e - s, 10);
      in_valid = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         tick();
         chk("W_err_sticky", err_timeout, 1);
         chk("W_in_ready", in_ready, 0);
         chk("W_no_pulse", {start_dbx, start_upd, start_ycalc, start_res}, 0);
      end
      in_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("W_err_cleared", err_timeout, 0);
      chk("W_in_ready_after", in_ready, 1);
      en_upd = 1'b1;
      tick();

      // asynchronous reset in the middle of the update stage
      mode_res = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!start_upd && n < 50) begin
         tick();
         n++;
      end
      tick();
      #3 rst_n = 1'b0;
      #1;
      chk("R_in_ready", in_ready, 1);
      chk("R_busy", busy, 0);
      chk("R_out_valid", out_valid, 0);
      chk("R_err", err_timeout, 0);
      chk("R_starts", {start_dbx, start_upd, start_ycalc, start_res}, 0);
      chk("R_tile_idx", tile_idx, 0);
      chk("R_y_flat", y_flat, 0);
      #2 rst_n = 1'b1;
      n = 0;
      repeat (20) begin
         tick();
         if (busy || start_dbx || start_upd || start_ycalc || start_res) n++;
      end
      chk("R_no_activity", n, 0);

      run_job(1'b0, mk(32'h6666_0000), mk(32'h6666_0001), lat, seq);
      chk("F_latency", lat, 25);
      chk("F_y", y_flat, {mk(32'h6666_0001), mk(32'h6666_0000)});
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
